// File: rtl/md_div_issue.sv
// ---------------------------------------------------------------------------
// md_div_issue
//   EXE-stage initiator for the iterative 32-bit divider. A DIV/DIVU sitting
//   in the EXE pipeline register is captured and issued over the divider's
//   valid/ready request handshake. EXE is stalled until the divider's
//   completion strobe. The remainder is then written to HI and the quotient
//   to LO. An exception flush during a division drains the in-flight
//   operation and discards its result.
//
//   Optional feature macro: DIV_ZERO_BYPASS_EN
//     When defined, a divide by zero is not sent to the divider. It goes
//     straight to DONE with lo = 32'hFFFF_FFFF and hi = dividend.
//
//   Parameters
//     WAIT_LIMIT   cycles allowed in WAIT before div_timeout sets (>= 36)
//     CNT_W        width of the wait-cycle counter
//
//   Ports
//     clk, rst          clock, asynchronous active-high reset
//     op_div            EXE holds a valid DIV/DIVU
//     op_signed         1 = DIV, 0 = DIVU
//     src_a, src_b      dividend, divisor
//     flush             exception/eret flush of EXE
//     exe_adv           EXE instruction moves to MEM this cycle
//     exe_stall         hold EXE
//     hilo_we           HI/LO write strobe
//     hi_wdata          remainder
//     lo_wdata          quotient
//     div_req           request valid to the divider
//     div_signed_o      signedness of the request
//     div_x, div_y      dividend and divisor to the divider
//     div_tready        divider accepts; transfer when div_req && div_tready
//     div_complete      divider result strobe (also high while idle)
//     div_q, div_r      divider quotient and remainder
//     div_timeout       sticky: a WAIT lasted WAIT_LIMIT cycles
// ---------------------------------------------------------------------------
module md_div_issue #(
    parameter int WAIT_LIMIT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_div,
    input  logic        op_signed,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        exe_adv,
    output logic        exe_stall,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        div_req,
    output logic        div_signed_o,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic        div_tready,
    input  logic        div_complete,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic        div_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(WAIT_LIMIT);

    state_t            state_r;
    state_t            state_s;
    logic              entered_r;   // first cycle after any state change
    logic [31:0]       x_r;
    logic [31:0]       y_r;
    logic              signed_r;
    logic [31:0]       hi_r;
    logic [31:0]       lo_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              timeout_r;

    logic              xfer_s;
    logic              latch_s;
    logic              cap_s;
    logic              bypass_s;
    logic              stall_s;
    logic              we_s;

    assign xfer_s = (state_r == S_REQ) && div_tready;

    // Next-state and control decode
    always_comb begin
        state_s  = state_r;
        latch_s  = 1'b0;
        cap_s    = 1'b0;
        bypass_s = 1'b0;
        stall_s  = 1'b0;
        we_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (op_div && !flush) begin
`ifdef DIV_ZERO_BYPASS_EN
                    if (src_b == 32'd0) begin
                        // Result is known without the divider; EXE is not held.
                        bypass_s = 1'b1;
                        state_s  = S_DONE;
                    end else begin
                        latch_s  = 1'b1;
                        stall_s  = 1'b1;
                        state_s  = S_REQ;
                    end
`else
                    latch_s = 1'b1;
                    stall_s = 1'b1;
                    state_s = S_REQ;
`endif
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                stall_s = 1'b1;
                if (xfer_s) begin
                    // Once accepted the divider must be allowed to finish.
                    state_s = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                stall_s = 1'b1;
                // cnt_r is zero only on the first WAIT cycle, when the
                // divider still shows its idle-high completion strobe.
                if ((cnt_r != {CNT_W{1'b0}}) && div_complete) begin
                    cap_s   = 1'b1;
                    state_s = flush ? S_IDLE : S_DONE;
                end else if (flush) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_DONE: begin
                we_s = exe_adv && !flush;
                if (exe_adv || flush) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            S_DRAIN: begin
                stall_s = op_div;
                if (!entered_r && div_complete) begin
                    if (op_div && !flush) begin
                        // Pending DIV goes straight to REQ, no IDLE bubble.
                        latch_s = 1'b1;
                        state_s = S_REQ;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_DRAIN;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register and first-cycle-in-state flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            entered_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            entered_r <= (state_s != state_r);
        end
    end

    // Operand latch; held stable through the request handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r      <= 32'd0;
            y_r      <= 32'd0;
            signed_r <= 1'b0;
        end else if (latch_s) begin
            x_r      <= src_a;
            y_r      <= src_b;
            signed_r <= op_signed;
        end else begin
            x_r      <= x_r;
            y_r      <= y_r;
            signed_r <= signed_r;
        end
    end

    // Result registers; held in DONE until EXE advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (cap_s) begin
            hi_r <= div_r;
            lo_r <= div_q;
        end else if (bypass_s) begin
            hi_r <= src_a;
            lo_r <= 32'hFFFF_FFFF;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Saturating WAIT cycle counter, cleared on entry to WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_s == S_WAIT) && (state_r != S_WAIT)) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == S_WAIT) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sticky timeout flag; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_r <= 1'b0;
        end else if ((state_r == S_WAIT) && (cnt_r == CNT_LIM)) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    // exe_stall must rise in the capture cycle itself, so it is decoded
    // combinationally; it is forced low while reset is asserted.
    assign exe_stall    = stall_s && !rst;
    assign hilo_we      = we_s;
    assign hi_wdata     = hi_r;
    assign lo_wdata     = lo_r;
    assign div_req      = (state_r == S_REQ);
    assign div_signed_o = signed_r;
    assign div_x        = x_r;
    assign div_y        = y_r;
    assign div_timeout  = timeout_r;

endmodule

// File: tb/tb_md_div_issue.sv
// ---------------------------------------------------------------------------
// tb_md_div_issue
//   Scoreboard bench for md_div_issue. Stimulus pushes the expected {HI,LO}
//   pair into a queue; a monitor pops and compares on every hilo_we. A small
//   behavioural divider answers the request handshake with a programmable
//   latency and keeps its completion strobe high while idle, including the
//   cycle right after it accepts a request.
// ---------------------------------------------------------------------------
module tb_md_div_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_div, op_signed, flush, exe_adv;
    logic [31:0] src_a, src_b;
    logic        exe_stall, hilo_we, div_req, div_signed_o, div_timeout;
    logic [31:0] hi_wdata, lo_wdata, div_x, div_y;
    logic        div_tready, div_complete;
    logic [31:0] div_q, div_r;

    always #5 clk = ~clk;

    md_div_issue dut (
        .clk(clk), .rst(rst), .op_div(op_div), .op_signed(op_signed),
        .src_a(src_a), .src_b(src_b), .flush(flush), .exe_adv(exe_adv),
        .exe_stall(exe_stall), .hilo_we(hilo_we), .hi_wdata(hi_wdata),
        .lo_wdata(lo_wdata), .div_req(div_req), .div_signed_o(div_signed_o),
        .div_x(div_x), .div_y(div_y), .div_tready(div_tready),
        .div_complete(div_complete), .div_q(div_q), .div_r(div_r),
        .div_timeout(div_timeout)
    );

    int tests = 0;
    int fails = 0;
    int xfers = 0;
    int exp_xfers = 0;
    logic [63:0] exp_q[$];

    // Reference: {remainder, quotient}, truncating division; /0 gives q=all ones, r=dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint na, nb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // ---------------- behavioural divider ----------------
    int          div_lat = 4;
    logic        tready_en = 1'b1;
    logic        rand_ready = 1'b0;
    logic        rnd_rdy = 1'b1;
    logic        dv_pend, dv_s;
    int          dv_busy;
    logic [31:0] dv_a, dv_b;

    assign div_complete = (dv_busy == 0);
    assign div_tready   = tready_en && (!rand_ready || rnd_rdy) && !dv_pend && (dv_busy == 0);

    always @(posedge clk) rnd_rdy <= ($urandom_range(0, 1) == 1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_pend <= 1'b0; dv_busy <= 0; dv_s <= 1'b0;
            dv_a <= 32'd0; dv_b <= 32'd0; div_q <= 32'd0; div_r <= 32'd0;
        end else if (div_req && div_tready) begin
            dv_pend <= 1'b1; dv_a <= div_x; dv_b <= div_y; dv_s <= div_signed_o;
        end else if (dv_pend) begin
            dv_pend <= 1'b0;
            dv_busy <= div_lat;
            {div_r, div_q} <= ref_div(dv_a, dv_b, dv_s);
        end else if (dv_busy > 0) begin
            dv_busy <= dv_busy - 1;
        end
    end

    // ---------------- monitor ----------------
    logic        stab_chk = 1'b0;
    logic [64:0] stab_v;
    logic [63:0] exp_v;

    always @(negedge clk) begin
        if (rst) begin
            stab_chk = 1'b0;
        end else begin
            if (div_req && div_tready) xfers++;
            if (stab_chk && div_req) begin
                tests++;
                if ({div_signed_o, div_x, div_y} !== stab_v) begin
                    fails++;
                    $display("FAIL req_stable: got %h, required %h", {div_signed_o, div_x, div_y}, stab_v);
                end
            end
            stab_chk = div_req && !div_tready;
            stab_v   = {div_signed_o, div_x, div_y};
            if (hilo_we) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL hilo_unexpected: got write hi=%h lo=%h, required no write", hi_wdata, lo_wdata);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({hi_wdata, lo_wdata} !== exp_v) begin
                        fails++;
                        $display("FAIL hilo_data: got hi=%h lo=%h, required hi=%h lo=%h",
                                 hi_wdata, lo_wdata, exp_v[63:32], exp_v[31:0]);
                    end
                end
                tests++;
                if (exe_stall !== 1'b0) begin
                    fails++;
                    $display("FAIL done_stall: got exe_stall=%b, required 0", exe_stall);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {exe_stall, hilo_we, div_req, div_signed_o, div_timeout} == 5'd0 &&
                    {div_x, div_y, hi_wdata, lo_wdata} == 128'd0 ? 64'd1 : 64'd0, 64'd1);
    endtask

    function automatic bit is_bypass(input logic [31:0] b);
`ifdef DIV_ZERO_BYPASS_EN
        return (b == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until exe_stall drops, i.e. the op reached DONE.
    task automatic wait_done(input string name);
        int n = 0;
        while (exe_stall && n < 300) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 300) begin
            fails++;
            $display("FAIL %s_timeout: got no DONE after %0d cycles, required DONE", name, n);
        end
    endtask

    // Issue one op from IDLE, hold DONE for 'hold' cycles, then advance.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
        exp_q.push_back(ref_div(a, b, s));
        if (!is_bypass(b)) exp_xfers++;
        op_div = 1'b1; src_a = a; src_b = b; op_signed = s; exe_adv = (hold == 0);
        #1;
        check("idle_stall", {63'd0, exe_stall}, {63'd0, !is_bypass(b)});
        tick();
        wait_done("op");
        repeat (hold) tick();
        exe_adv = 1'b1;
        tick();
        op_div = 1'b0; exe_adv = 1'b0;
        tick();
    endtask

    // ---------------- stimulus ----------------
    int x0;
    logic [31:0] ra, rb;

    initial begin
        rst = 1'b1; op_div = 1'b0; op_signed = 1'b0; flush = 1'b0; exe_adv = 1'b0;
        src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b0;
        tick();

        // DIVU 100/7 with exe_adv tied high
        div_lat = 8; x0 = xfers;
        run_op(32'd100, 32'd7, 1'b0, 0);
        check("divu_xfers", 64'(xfers - x0), 64'd1);
        check("divu_result", {hi_wdata, lo_wdata}, {32'd2, 32'd14});

        // Signed corner cases
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        check("div_ovf_result", {hi_wdata, lo_wdata}, {32'd0, 32'h8000_0000});

        // DONE held 4 cycles: no write, no re-issue
        x0 = xfers;
        run_op(32'd1000, 32'd33, 1'b0, 4);
        check("hold_xfers", 64'(xfers - x0), 64'd1);

        // Flush 5 cycles into WAIT; new DIV 9/3 waits in DRAIN, then issues
        div_lat = 20; x0 = xfers;
        op_div = 1'b1; src_a = 32'd1000; src_b = 32'd10; op_signed = 1'b0;
        tick(); tick();
        repeat (5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; src_a = 32'd9; src_b = 32'd3; op_signed = 1'b1;
        exp_q.push_back(ref_div(32'd9, 32'd3, 1'b1));
        check("drain_stall", {63'd0, exe_stall}, 64'd1);
        div_lat = 5;
        wait_done("drain");
        check("drain_result", {hi_wdata, lo_wdata}, {32'd0, 32'd3});
        exe_adv = 1'b1; tick();
        op_div = 1'b0; exe_adv = 1'b0; tick();
        check("drain_xfers", 64'(xfers - x0), 64'd2);
        exp_xfers += 2;

        // tready low in REQ; flush in the 2nd cycle drops the request
        tready_en = 1'b0; x0 = xfers;
        op_div = 1'b1; src_a = 32'h1234_5678; src_b = 32'h0000_0042; op_signed = 1'b1;
        tick();
        check("req1_operands", {31'd0, div_req, div_signed_o, div_x}, {31'd0, 1'b1, 1'b1, 32'h1234_5678});
        tick();
        check("req2_operands", {div_x, div_y}, {32'h1234_5678, 32'h0000_0042});
        flush = 1'b1;
        tick();
        flush = 1'b0; op_div = 1'b0;
        check("req_flush_drop", {62'd0, div_req, hilo_we}, 64'd0);
        tick();
        tready_en = 1'b1;
        check("req_flush_xfers", 64'(xfers - x0), 64'd0);

        // Divide by zero (bypassed only when the feature is built in)
        x0 = xfers;
        run_op(32'd5, 32'd0, 1'b0, 0);
        check("div0_result", {hi_wdata, lo_wdata}, {32'd5, 32'hFFFF_FFFF});
        check("div0_xfers", 64'(xfers - x0), is_bypass(32'd0) ? 64'd0 : 64'd1);

        // Randomized ops with random divider readiness
        rand_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            ra = $urandom();
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 20);
                default: rb = $urandom();
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            div_lat = $urandom_range(1, 34);
            run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        rand_ready = 1'b0;
        check("no_timeout_yet", {63'd0, div_timeout}, 64'd0);

        // Slow divider: WAIT overruns the limit
        div_lat = 45;
        run_op(32'd77, 32'd5, 1'b0, 0);
        check("timeout_set", {63'd0, div_timeout}, 64'd1);

        // Reset mid-WAIT
        div_lat = 20;
        op_div = 1'b1; src_a = 32'hDEAD_BEEF; src_b = 32'd3; op_signed = 1'b1;
        tick(); tick(); tick(); tick();
        exp_xfers++;
        rst = 1'b1; op_div = 1'b0;
        #1;
        check_zero("reset_mid_wait");
        tick();
        rst = 1'b0;
        tick();
        check_zero("after_reset");

        // Normal op after reset
        div_lat = 6;
        run_op(32'd50, 32'd7, 1'b0, 2);

        check("total_xfers", 64'(xfers), 64'(exp_xfers));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
